// File: rtl/pipe_stage_reg_pkg.sv
// Shared MIPS pipeline-boundary constants and helpers for pipe_stage_reg.
// NOP_WORD is the payload a stage holds after reset or a flush (a bubble).
package pipe_stage_reg_pkg;

  // sll $0,$0,0 encodes as all zeros
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  localparam int IFID_W  = 64;
  localparam int IDEX_W  = 148;
  localparam int EXMEM_W = 107;
  localparam int MEMWB_W = 71;

  // Source of the main entry's next payload.
  typedef enum logic {
    SRC_IN   = 1'b0,
    SRC_SKID = 1'b1
  } main_src_e;

  function automatic logic [1:0] entries_held(input logic main_v, input logic skid_v);
    return {1'b0, main_v} + {1'b0, skid_v};
  endfunction

endpackage

// File: rtl/pipe_entry.sv
// One pipeline entry: a valid bit plus WIDTH-bit payload with load, drop
// (invalidate, payload kept) and clear-to-INIT_VALUE (flush).
module pipe_entry #(
  parameter int              WIDTH      = 32,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic             i_drop,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_data  <= INIT_VALUE;
    end else if (i_clear) begin
      o_valid <= 1'b0;
      o_data  <= INIT_VALUE;
    end else if (i_load) begin
      o_valid <= 1'b1;
      o_data  <= i_data;
    end else if (i_drop) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// MIPS datapath stage register with valid/ready, stall and flush. SKID=1 adds
// a second entry so o_ready is a flop, cutting the ready chain between stages.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] INIT_VALUE = WIDTH'(NOP_WORD),
  parameter int               SKID       = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_stall,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_ready,
  output logic [1:0]       o_count
);

  logic             main_valid;
  logic [WIDTH-1:0] main_data;
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic             accept;
  logic             emit;
  logic             main_load;
  logic             main_drop;
  main_src_e        main_src;
  logic [WIDTH-1:0] main_din;

  assign accept = i_valid & o_ready;
  assign emit   = main_valid & i_ready & ~i_stall;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    main_load = 1'b0;
    main_drop = 1'b0;
    main_src  = SRC_IN;
    if (skid_valid) begin
      // Full stage: o_ready is low, so the only movement is skid -> main.
      if (emit) begin
        main_load = 1'b1;
        main_src  = SRC_SKID;
      end
    end else if (accept && (!main_valid || emit)) begin
      main_load = 1'b1;
    end else if (emit && !accept) begin
      main_drop = 1'b1;
    end
  end

  assign main_din = (main_src == SRC_SKID) ? skid_data : i_data;

  pipe_entry #(
    .WIDTH      (WIDTH),
    .INIT_VALUE (INIT_VALUE)
  ) u_main (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (i_flush),
    .i_load  (main_load),
    .i_drop  (main_drop),
    .i_data  (main_din),
    .o_valid (main_valid),
    .o_data  (main_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      // A beat arriving while main is blocked parks here; it leaves only via main.
      pipe_entry #(
        .WIDTH      (WIDTH),
        .INIT_VALUE (INIT_VALUE)
      ) u_skid (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (i_flush),
        .i_load  (accept & main_valid & ~emit),
        .i_drop  (emit),
        .i_data  (i_data),
        .o_valid (skid_valid),
        .o_data  (skid_data)
      );
      assign o_ready = ~skid_valid;
    end else begin : g_pass
      assign skid_valid = 1'b0;
      assign skid_data  = INIT_VALUE;
      assign o_ready    = ~main_valid | (i_ready & ~i_stall);
    end
  endgenerate

  assign o_valid = main_valid;
  assign o_data  = main_data;
  assign o_count = entries_held(main_valid, skid_valid);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vector table (SKID=1), hand sequences for
// SKID=0 and async reset, then random traffic against a queue model, both modes.
module tb_pipe_stage_reg;

  localparam logic [31:0] P_INIT = 32'h1357_9BDF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        s_flush, s_stall, s_in_valid, s_in_ready;
  logic [31:0] s_in_data;
  logic        s_out_ready, s_out_valid;
  logic [31:0] s_out_data;
  logic [1:0]  s_out_count;

  logic        p_flush, p_stall, p_in_valid, p_in_ready;
  logic [31:0] p_in_data;
  logic        p_out_ready, p_out_valid;
  logic [31:0] p_out_data;
  logic [1:0]  p_out_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.WIDTH(32), .SKID(1)) dut_skid (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_flush (s_flush),
    .i_stall (s_stall),
    .i_valid (s_in_valid),
    .i_data  (s_in_data),
    .o_ready (s_out_ready),
    .o_valid (s_out_valid),
    .o_data  (s_out_data),
    .i_ready (s_in_ready),
    .o_count (s_out_count)
  );

  pipe_stage_reg #(.WIDTH(32), .INIT_VALUE(P_INIT), .SKID(0)) dut_pass (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_flush (p_flush),
    .i_stall (p_stall),
    .i_valid (p_in_valid),
    .i_data  (p_in_data),
    .o_ready (p_out_ready),
    .o_valid (p_out_valid),
    .o_data  (p_out_data),
    .i_ready (p_in_ready),
    .o_count (p_out_count)
  );

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        r;
    logic        st;
    logic        fl;
    logic        ev;
    logic [31:0] ed;
    logic        er;
    logic [1:0]  ec;
    logic        cd;
  } vec_t;

  vec_t tbl[$];
  logic [31:0] q1[$];
  logic [31:0] q0[$];

  function automatic vec_t mk(input logic v, input logic [31:0] d, input logic r,
                              input logic st, input logic fl, input logic ev,
                              input logic [31:0] ed, input logic er,
                              input logic [1:0] ec, input logic cd);
    vec_t t;
    t.v = v; t.d = d; t.r = r; t.st = st; t.fl = fl;
    t.ev = ev; t.ed = ed; t.er = er; t.ec = ec; t.cd = cd;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    s_flush = 0; s_stall = 0; s_in_valid = 0; s_in_ready = 0; s_in_data = '0;
    p_flush = 0; p_stall = 0; p_in_valid = 0; p_in_ready = 0; p_in_data = '0;
  endtask

  task automatic do_reset(input bit check_it);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    if (check_it) begin
      check("rst_s_valid", s_out_valid, 0);
      check("rst_s_data",  s_out_data,  0);
      check("rst_s_ready", s_out_ready, 1);
      check("rst_s_count", s_out_count, 0);
      check("rst_p_valid", p_out_valid, 0);
      check("rst_p_data",  p_out_data,  P_INIT);
      check("rst_p_ready", p_out_ready, 1);
    end
    rst_n = 1'b1;
    q1.delete();
    q0.delete();
  endtask

  initial begin
    idle_inputs();
    do_reset(1'b1);

    // ---------------- directed table, SKID=1 ----------------
    tbl.push_back(mk(1, 'hA, 1, 0, 0, 1, 'hA, 1, 1, 1));
    tbl.push_back(mk(1, 'hB, 1, 0, 0, 1, 'hB, 1, 1, 1));
    tbl.push_back(mk(1, 'hC, 1, 0, 0, 1, 'hC, 1, 1, 1));
    tbl.push_back(mk(0, 0,   1, 0, 0, 0, 0,   1, 0, 0));
    tbl.push_back(mk(1, 1,   0, 0, 0, 1, 1,   1, 1, 1));
    tbl.push_back(mk(1, 2,   0, 0, 0, 1, 1,   0, 2, 1));
    tbl.push_back(mk(1, 3,   0, 0, 0, 1, 1,   0, 2, 1));
    tbl.push_back(mk(1, 3,   1, 0, 0, 1, 2,   1, 1, 1));
    tbl.push_back(mk(1, 3,   1, 0, 0, 1, 3,   1, 1, 1));
    tbl.push_back(mk(0, 0,   1, 0, 0, 0, 0,   1, 0, 0));
    tbl.push_back(mk(1, 5,   1, 0, 0, 1, 5,   1, 1, 1));
    tbl.push_back(mk(0, 0,   1, 1, 0, 1, 5,   1, 1, 1));
    tbl.push_back(mk(0, 0,   1, 1, 0, 1, 5,   1, 1, 1));
    tbl.push_back(mk(0, 0,   1, 1, 0, 1, 5,   1, 1, 1));
    tbl.push_back(mk(0, 0,   1, 0, 0, 0, 0,   1, 0, 0));
    tbl.push_back(mk(1, 7,   0, 0, 0, 1, 7,   1, 1, 1));
    tbl.push_back(mk(1, 8,   0, 0, 0, 1, 7,   0, 2, 1));
    tbl.push_back(mk(1, 9,   0, 0, 1, 0, 0,   1, 0, 1));
    tbl.push_back(mk(0, 0,   1, 0, 0, 0, 0,   1, 0, 1));
    tbl.push_back(mk(1, 6,   1, 0, 0, 1, 6,   1, 1, 1));
    tbl.push_back(mk(1, 'hE, 1, 1, 1, 0, 0,   1, 0, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      s_in_valid = tbl[i].v; s_in_data = tbl[i].d; s_in_ready = tbl[i].r;
      s_stall = tbl[i].st; s_flush = tbl[i].fl;
      @(posedge clk);
      #1;
      check($sformatf("row%0d_valid", i), s_out_valid, tbl[i].ev);
      check($sformatf("row%0d_ready", i), s_out_ready, tbl[i].er);
      check($sformatf("row%0d_count", i), s_out_count, tbl[i].ec);
      if (tbl[i].cd) check($sformatf("row%0d_data", i), s_out_data, tbl[i].ed);
    end

    // ---------------- SKID=0 combinational ready ----------------
    do_reset(1'b0);
    @(negedge clk);
    p_in_valid = 1; p_in_data = 32'h11; p_in_ready = 0;
    @(negedge clk);
    p_in_data = 32'h22;
    #1 check("pass_ready_blocked", p_out_ready, 0);
    check("pass_hold_data", p_out_data, 32'h11);
    p_in_ready = 1;
    #1 check("pass_ready_comb", p_out_ready, 1);
    @(posedge clk);
    #1 check("pass_swap_data", p_out_data, 32'h22);
    check("pass_swap_valid", p_out_valid, 1);
    @(negedge clk);
    p_stall = 1;
    #1 check("pass_ready_stall", p_out_ready, 0);
    p_stall = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      p_in_valid = 1; p_in_data = 32'h100 + i; p_in_ready = 1;
      @(posedge clk);
      #1 check($sformatf("pass_tput%0d", i), p_out_data, 32'h100 + i);
    end

    // ---------------- async reset mid-cycle with two entries ----------------
    do_reset(1'b0);
    @(negedge clk);
    s_in_valid = 1; s_in_data = 32'h21; s_in_ready = 0;
    @(negedge clk);
    s_in_data = 32'h22;
    @(negedge clk);
    s_in_valid = 0;
    #1 check("arst_pre_count", s_out_count, 2);
    #1 rst_n = 1'b0;
    #1;
    check("arst_valid", s_out_valid, 0);
    check("arst_data",  s_out_data,  0);
    check("arst_ready", s_out_ready, 1);
    check("arst_count", s_out_count, 0);
    @(negedge clk);
    s_in_ready = 1;
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("arst_no_emit", s_out_valid, 0);

    // ---------------- random traffic vs queue model ----------------
    do_reset(1'b0);
    for (int c = 0; c < 400; c++) begin
      logic rdy1, rdy0;
      @(negedge clk);
      s_in_valid = 1'($urandom_range(0, 1)); s_in_data = $urandom;
      s_in_ready = ($urandom_range(0, 3) != 0); s_stall = ($urandom_range(0, 5) == 0);
      s_flush = ($urandom_range(0, 19) == 0);
      p_in_valid = 1'($urandom_range(0, 1)); p_in_data = $urandom;
      p_in_ready = ($urandom_range(0, 3) != 0); p_stall = ($urandom_range(0, 5) == 0);
      p_flush = ($urandom_range(0, 19) == 0);
      #1;
      rdy1 = (q1.size() < 2);
      rdy0 = (q0.size() == 0) || (p_in_ready && !p_stall);
      check("rnd_s_valid", s_out_valid, q1.size() > 0);
      check("rnd_s_ready", s_out_ready, rdy1);
      check("rnd_s_count", s_out_count, q1.size());
      if (q1.size() > 0) check("rnd_s_data", s_out_data, q1[0]);
      check("rnd_p_valid", p_out_valid, q0.size() > 0);
      check("rnd_p_ready", p_out_ready, rdy0);
      check("rnd_p_count", p_out_count, q0.size());
      if (q0.size() > 0) check("rnd_p_data", p_out_data, q0[0]);

      if (s_flush) q1.delete();
      else begin
        if (q1.size() > 0 && s_in_ready && !s_stall) void'(q1.pop_front());
        if (s_in_valid && rdy1) q1.push_back(s_in_data);
      end
      if (p_flush) q0.delete();
      else begin
        if (q0.size() > 0 && p_in_ready && !p_stall) void'(q0.pop_front());
        if (p_in_valid && rdy0) q0.push_back(p_in_data);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
